// File: rtl/mult_arbiter.sv
// Round-robin arbiter and sequencer sharing one registered multiply-add unit
// among four requesters; results return in issue order through a 2-entry FIFO.
module mult_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int RW   = 17
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] opa_in,
  input  logic [NREQ*W-1:0] opb_in,
  input  logic [NREQ*W-1:0] opc_in,
  output logic [NREQ-1:0]   gnt,
  output logic [W-1:0]      mult_opa,
  output logic [W-1:0]      mult_opb,
  output logic [W-1:0]      mult_opc,
  output logic              mult_reset,
  input  logic [RW-1:0]     mult_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_id,
  output logic [RW-1:0]     rsp_data,
  output logic              busy
);

  logic [1:0]    r_rr_ptr;
  logic          r_inflight;
  logic [1:0]    r_inflight_id;
  logic [1:0]    r_count;
  logic          r_rd_ptr;
  logic          r_wr_ptr;
  logic [1:0]    r_fifo_id   [2];
  logic [RW-1:0] r_fifo_data [2];

  logic          w_pop;
  logic          w_push;
  logic [2:0]    w_occ;
  logic          w_issue_ok;
  logic          w_found;
  logic [1:0]    w_gnt_id;
  logic [1:0]    w_idx;

  assign w_pop      = rsp_valid & rsp_ready;
  assign w_push     = r_inflight;
  assign w_occ      = {1'b0, r_count} + {2'b00, r_inflight};
  // Pop frees a slot this same cycle, so a full pipeline can still issue.
  assign w_issue_ok = (w_occ < 3'd2) || ((w_occ == 3'd2) && w_pop);

  always_comb begin
    w_found  = 1'b0;
    w_gnt_id = '0;
    w_idx    = '0;
    gnt      = '0;
    if (reset_n && w_issue_ok) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        w_idx = r_rr_ptr + 2'(k);
        if (!w_found && req[w_idx]) begin
          w_found  = 1'b1;
          w_gnt_id = w_idx;
        end
      end
    end
    if (w_found) gnt[w_gnt_id] = 1'b1;
  end

  assign mult_opa   = w_found ? opa_in[w_gnt_id*W +: W] : '0;
  assign mult_opb   = w_found ? opb_in[w_gnt_id*W +: W] : '0;
  assign mult_opc   = w_found ? opc_in[w_gnt_id*W +: W] : '0;
  assign mult_reset = ~reset_n;

  assign rsp_valid  = (r_count != 2'd0);
  assign rsp_id     = r_fifo_id[r_rd_ptr];
  assign rsp_data   = r_fifo_data[r_rd_ptr];
  assign busy       = r_inflight | rsp_valid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr       <= '0;
      r_inflight     <= 1'b0;
      r_inflight_id  <= '0;
      r_count        <= '0;
      r_rd_ptr       <= 1'b0;
      r_wr_ptr       <= 1'b0;
      r_fifo_id[0]   <= '0;
      r_fifo_id[1]   <= '0;
      r_fifo_data[0] <= '0;
      r_fifo_data[1] <= '0;
    end else begin
      r_inflight <= w_found;
      if (w_found) begin
        r_rr_ptr      <= w_gnt_id + 2'd1;
        r_inflight_id <= w_gnt_id;
      end
      if (w_push) begin
        r_fifo_id[r_wr_ptr]   <= r_inflight_id;
        r_fifo_data[r_wr_ptr] <= mult_result;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(w_push && !w_pop && (r_count == 2'd2)));

endmodule
